// File: rtl/capture_trigger_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : capture_trigger_ctrl
// Purpose  : Circular pre/post-trigger capture sequencer and channel trigger
//            combiner. Optional forced trigger on timeout: define AUTO_TRIG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module capture_trigger_ctrl #(
    parameter int NUM_CH       = 5,
`ifdef AUTO_TRIG_EN
    parameter int AUTO_TIMEOUT = 1000000,
`endif
    parameter int ADDR_W       = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture_run,
    input  logic              capture_abort,
    input  logic              smpl_en,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic [NUM_CH-1:0] ChxTrig,
`ifdef AUTO_TRIG_EN
    output logic              auto_trig,
`endif
    output logic              set_armed,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              triggered,
    output logic              capture_done,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] trig_pos_l_q, trig_pos_l_d;
    logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic              triggered_q, triggered_d;
    logic              capture_done_q, capture_done_d;
    logic              set_armed_q, set_armed_d;

    logic              w_active;
    logic              w_we;
    logic              w_fire;
    logic [ADDR_W-1:0] w_fill_target;
    logic              w_fill_last;
    logic              w_post_last;

`ifdef AUTO_TRIG_EN
    localparam int TMO_W = $clog2(AUTO_TIMEOUT) + 1;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             auto_trig_q, auto_trig_d;
    logic             w_timeout;

    assign w_timeout = (tmo_q == TMO_W'(AUTO_TIMEOUT - 1));
    assign w_fire    = (&ChxTrig) || w_timeout;
`else
    assign w_fire    = &ChxTrig;
`endif

    assign w_active = (state_q == S_FILL) || (state_q == S_ARMED) || (state_q == S_POST);
    assign w_we     = smpl_en && w_active;

    // Two's complement of trig_pos_l equals DEPTH - trig_pos_l for 1..DEPTH-1
    assign w_fill_target = ~trig_pos_l_q + 1'b1;
    assign w_fill_last   = (pre_cnt_q + 1'b1) == w_fill_target;
    assign w_post_last   = (post_cnt_q + 1'b1) == trig_pos_l_q;

    always_comb begin
        state_d        = state_q;
        waddr_d        = w_we ? waddr_q + 1'b1 : waddr_q;
        trig_addr_d    = trig_addr_q;
        trig_pos_l_d   = trig_pos_l_q;
        pre_cnt_d      = pre_cnt_q;
        post_cnt_d     = post_cnt_q;
        triggered_d    = triggered_q;
        capture_done_d = capture_done_q;
        set_armed_d    = set_armed_q;
`ifdef AUTO_TRIG_EN
        tmo_d          = tmo_q;
        auto_trig_d    = auto_trig_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (capture_run) begin
                    trig_pos_l_d   = (trig_pos == '0) ? ADDR_W'(1) : trig_pos;
                    waddr_d        = '0;
                    pre_cnt_d      = '0;
                    triggered_d    = 1'b0;
                    capture_done_d = 1'b0;
`ifdef AUTO_TRIG_EN
                    auto_trig_d    = 1'b0;
`endif
                    state_d        = S_FILL;
                end
            end
            S_FILL: begin
                if (smpl_en) begin
                    pre_cnt_d = pre_cnt_q + 1'b1;
                    if (w_fill_last) begin
                        state_d     = S_ARMED;
                        set_armed_d = 1'b1;
`ifdef AUTO_TRIG_EN
                        tmo_d       = '0;
`endif
                    end
                end
            end
            S_ARMED: begin
`ifdef AUTO_TRIG_EN
                tmo_d = tmo_q + 1'b1;
`endif
                if (w_fire) begin
                    trig_addr_d = waddr_q;
                    triggered_d = 1'b1;
                    set_armed_d = 1'b0;
                    post_cnt_d  = smpl_en ? ADDR_W'(1) : '0;
`ifdef AUTO_TRIG_EN
                    auto_trig_d = ~(&ChxTrig);
`endif
                    // A write in the trigger cycle is post sample #1
                    if (smpl_en && (trig_pos_l_q == ADDR_W'(1))) begin
                        state_d        = S_DONE;
                        capture_done_d = 1'b1;
                    end else begin
                        state_d = S_POST;
                    end
                end
            end
            S_POST: begin
                if (smpl_en) begin
                    post_cnt_d = post_cnt_q + 1'b1;
                    if (w_post_last) begin
                        state_d        = S_DONE;
                        capture_done_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (capture_abort) begin
            state_d        = S_IDLE;
            waddr_d        = w_we ? waddr_q + 1'b1 : waddr_q;
            trig_addr_d    = trig_addr_q;
            set_armed_d    = 1'b0;
            triggered_d    = 1'b0;
            capture_done_d = 1'b0;
`ifdef AUTO_TRIG_EN
            auto_trig_d    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            waddr_q        <= '0;
            trig_addr_q    <= '0;
            trig_pos_l_q   <= '0;
            pre_cnt_q      <= '0;
            post_cnt_q     <= '0;
            triggered_q    <= 1'b0;
            capture_done_q <= 1'b0;
            set_armed_q    <= 1'b0;
`ifdef AUTO_TRIG_EN
            tmo_q          <= '0;
            auto_trig_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            waddr_q        <= waddr_d;
            trig_addr_q    <= trig_addr_d;
            trig_pos_l_q   <= trig_pos_l_d;
            pre_cnt_q      <= pre_cnt_d;
            post_cnt_q     <= post_cnt_d;
            triggered_q    <= triggered_d;
            capture_done_q <= capture_done_d;
            set_armed_q    <= set_armed_d;
`ifdef AUTO_TRIG_EN
            tmo_q          <= tmo_d;
            auto_trig_q    <= auto_trig_d;
`endif
        end
    end

    assign set_armed    = set_armed_q;
    assign we           = w_we;
    assign waddr        = waddr_q;
    assign trig_addr    = trig_addr_q;
    assign triggered    = triggered_q;
    assign capture_done = capture_done_q;
    assign busy         = w_active;
`ifdef AUTO_TRIG_EN
    assign auto_trig    = auto_trig_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_capture_trigger_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_capture_trigger_ctrl
// Purpose  : Self-checking bench for capture_trigger_ctrl (ADDR_W = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_capture_trigger_ctrl;

    localparam int NUM_CH = 5;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              capture_run;
    logic              capture_abort;
    logic              smpl_en;
    logic [ADDR_W-1:0] trig_pos;
    logic [NUM_CH-1:0] ChxTrig;
    logic              set_armed;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] trig_addr;
    logic              triggered;
    logic              capture_done;
    logic              busy;
`ifdef AUTO_TRIG_EN
    logic              auto_trig;
`endif

    capture_trigger_ctrl #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .capture_run   (capture_run),
        .capture_abort (capture_abort),
        .smpl_en       (smpl_en),
        .trig_pos      (trig_pos),
        .ChxTrig       (ChxTrig),
`ifdef AUTO_TRIG_EN
        .auto_trig     (auto_trig),
`endif
        .set_armed     (set_armed),
        .we            (we),
        .waddr         (waddr),
        .trig_addr     (trig_addr),
        .triggered     (triggered),
        .capture_done  (capture_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Capture model: writes counted per capture, arming derived from the count
    bit m_run, m_trig, m_done;
    int m_waddr, m_taddr, m_nwr, m_post, m_tp;

    task automatic model_reset();
        m_run = 0; m_trig = 0; m_done = 0;
        m_waddr = 0; m_taddr = 0; m_nwr = 0; m_post = 0; m_tp = 1;
    endtask

    function automatic bit model_armed();
        return m_run && !m_trig && (m_nwr >= DEPTH - m_tp);
    endfunction

    task automatic model_step();
        bit armed;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (capture_abort) begin
            if (m_run && smpl_en) m_waddr = (m_waddr + 1) % DEPTH;
            m_run = 0; m_trig = 0; m_done = 0;
        end else if (!m_run) begin
            if (capture_run) begin
                m_run = 1; m_trig = 0; m_done = 0;
                m_nwr = 0; m_post = 0; m_waddr = 0;
                m_tp = (trig_pos == 0) ? 1 : int'(trig_pos);
            end
        end else begin
            armed = model_armed();
            if (armed && (&ChxTrig)) begin
                m_trig = 1; m_taddr = m_waddr; m_post = 0;
            end
            if (smpl_en) begin
                m_waddr = (m_waddr + 1) % DEPTH;
                m_nwr++;
                if (m_trig) m_post++;
            end
            if (m_trig && m_post == m_tp) begin
                m_run = 0; m_done = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("busy",         int'(busy),         int'(m_run));
            chk("we",           int'(we),           int'(m_run && smpl_en));
            chk("waddr",        int'(waddr),        m_waddr);
            chk("trig_addr",    int'(trig_addr),    m_taddr);
            chk("triggered",    int'(triggered),    int'(m_trig));
            chk("capture_done", int'(capture_done), int'(m_done));
            chk("set_armed",    int'(set_armed),    int'(model_armed()));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    int nw;

    initial begin
        rst_n = 1'b0; capture_run = 1'b0; capture_abort = 1'b0;
        smpl_en = 1'b0; trig_pos = '0; ChxTrig = '0;
        model_reset();
        tick(); tick();
        chk("rst_we", int'(we), 0);
        chk("rst_waddr", int'(waddr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_set_armed", int'(set_armed), 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();

        // Basic capture, trig_pos = 4, all channels triggering
        trig_pos = 4'd4; ChxTrig = '1; smpl_en = 1'b1;
        tick();
        capture_run = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            capture_run = 1'b0;
            @(negedge clk);
            chk("t1_we", int'(we), int'(c <= 16));
            chk("t1_waddr", int'(waddr), (c <= 16) ? c - 1 : 0);
            chk("t1_set_armed", int'(set_armed), int'(c == 13));
            chk("t1_triggered", int'(triggered), int'(c >= 14));
            chk("t1_done", int'(capture_done), int'(c >= 17));
            if (c >= 14) chk("t1_trig_addr", int'(trig_addr), 12);
        end

        // Channel 2 held low until waddr has wrapped to 3 while armed
        ChxTrig = 5'b11011;
        capture_run = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            capture_run = 1'b0;
            if (m_run && m_nwr > DEPTH && m_waddr == 3) ChxTrig = '1;
            if (m_done) break;
        end
        @(negedge clk);
        chk("t2_done", int'(capture_done), 1);
        chk("t2_trig_addr", int'(trig_addr), 3);
        chk("t2_waddr", int'(waddr), 7);

        // Sparse samples with trig_pos = 15: minimum fill of one sample
        tick();
        trig_pos = 4'd15; ChxTrig = '1; smpl_en = 1'b0; capture_run = 1'b1;
        nw = 0;
        for (int k = 0; k < 80; k++) begin
            tick();
            capture_run = 1'b0;
            smpl_en = (k % 3 == 2);
            @(negedge clk);
            if (we) nw++;
        end
        chk("t3_writes", nw, 16);
        chk("t3_done", int'(capture_done), 1);
        chk("t3_trig_addr", int'(trig_addr), 1);

        // Abort while armed with a simultaneous full trigger
        tick();
        trig_pos = 4'd4; ChxTrig = '0; smpl_en = 1'b1; capture_run = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            capture_run = 1'b0;
            if (model_armed()) break;
        end
        capture_abort = 1'b1; ChxTrig = '1; smpl_en = 1'b0;
        tick();
        capture_abort = 1'b0;
        @(negedge clk);
        chk("t4_busy", int'(busy), 0);
        chk("t4_triggered", int'(triggered), 0);
        chk("t4_set_armed", int'(set_armed), 0);
        tick();
        capture_run = 1'b1; smpl_en = 1'b1;
        tick();
        capture_run = 1'b0;
        @(negedge clk);
        chk("t4_restart_waddr", int'(waddr), 0);
        chk("t4_restart_busy", int'(busy), 1);

        // Asynchronous reset in the middle of the post-trigger phase
        for (int k = 0; k < 40; k++) begin
            tick();
            if (m_run && m_trig) break;
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_rst_we", int'(we), 0);
        chk("t5_rst_waddr", int'(waddr), 0);
        chk("t5_rst_trig_addr", int'(trig_addr), 0);
        chk("t5_rst_triggered", int'(triggered), 0);
        chk("t5_rst_done", int'(capture_done), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_set_armed", int'(set_armed), 0);
        tick();
        rst_n = 1'b1;

        // Repeated capture_run during FILL must not restart the capture
        tick();
        capture_run = 1'b1;
        nw = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            capture_run = (k == 3);
            @(negedge clk);
            if (we) nw++;
        end
        chk("t5_writes", nw, 16);
        chk("t5_done", int'(capture_done), 1);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            tick();
            capture_run   = ($urandom_range(0, 9) == 0);
            capture_abort = ($urandom_range(0, 79) == 0);
            smpl_en       = capture_abort ? 1'b0 : ($urandom_range(0, 2) != 0);
            trig_pos      = ADDR_W'($urandom_range(0, DEPTH - 1));
            ChxTrig       = ($urandom_range(0, 3) == 0) ? '1 : NUM_CH'($urandom);
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
